// File: rtl/bellek_erisim_birimi.sv
// Memory-stage load/store unit: drives one word-wide valid/ready data-memory
// transaction per operation and formats load results for write-back.
module bellek_erisim_birimi (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek_gecerli_i,
  input  logic [3:0]  islem_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] yazilacak_veri_i,
  input  logic [4:0]  hedef_yazmac_i,
  output logic        durdur_o,
  output logic        bellek_istek_o,
  output logic        bellek_yaz_o,
  output logic [31:0] bellek_adres_o,
  output logic [3:0]  bellek_maske_o,
  output logic [31:0] bellek_yaz_veri_o,
  input  logic        bellek_hazir_i,
  input  logic [31:0] bellek_oku_veri_i,
  output logic        geri_yaz_gecerli_o,
  output logic [4:0]  geri_yaz_yazmac_o,
  output logic [31:0] geri_yaz_veri_o,
  output logic        hizasiz_hata_o
);

  localparam int unsigned ADRES_W = 32;
  localparam int unsigned VERI_W  = 32;
  localparam int unsigned YAZMAC_W = 5;
  localparam int unsigned SERIT_N = VERI_W / 8;

  typedef enum logic {
    BOSTA,
    BEKLE
  } durum_t;

  durum_t durum;

  // Decoded view of the operation currently presented by the execute stage
  logic [1:0]          boyut;
  logic [1:0]          ofset;
  logic                hizasiz;
  logic [SERIT_N-1:0]  serit_maske;
  logic [VERI_W-1:0]   serit_veri;

  // Load details kept for formatting the returned word
  logic [1:0]          kayit_boyut;
  logic [1:0]          kayit_ofset;
  logic                kayit_isaretsiz;
  logic [YAZMAC_W-1:0] kayit_hedef;

  logic [VERI_W-1:0]   kaydirilmis;
  logic [VERI_W-1:0]   bicimli_veri;

  assign boyut = islem_i[1:0];
  assign ofset = adres_i[1:0];

  // Size 2'b11 is handled as a word everywhere, so boyut[1] selects word rules
  always_comb begin
    hizasiz = 1'b0;
    if (boyut == 2'b01) begin
      hizasiz = ofset[0];
    end else if (boyut[1]) begin
      hizasiz = (ofset != 2'b00);
    end
  end

  always_comb begin
    serit_maske = 4'b1111;
    serit_veri  = yazilacak_veri_i;
    case (boyut)
      2'b00: begin
        serit_maske = 4'b0001 << ofset;
        serit_veri  = {4{yazilacak_veri_i[7:0]}};
      end
      2'b01: begin
        serit_maske = 4'b0011 << ofset;
        serit_veri  = {2{yazilacak_veri_i[15:0]}};
      end
      default: begin
        serit_maske = 4'b1111;
        serit_veri  = yazilacak_veri_i;
      end
    endcase
  end

  // Stall only while an aligned request is being launched or is still outstanding
  always_comb begin
    durdur_o = 1'b0;
    case (durum)
      BOSTA:   durdur_o = istek_gecerli_i && !hizasiz;
      BEKLE:   durdur_o = !bellek_hazir_i;
      default: durdur_o = 1'b0;
    endcase
  end

  assign kaydirilmis = bellek_oku_veri_i >> {kayit_ofset, 3'b000};

  always_comb begin
    bicimli_veri = kaydirilmis;
    case (kayit_boyut)
      2'b00:   bicimli_veri = {{24{!kayit_isaretsiz && kaydirilmis[7]}}, kaydirilmis[7:0]};
      2'b01:   bicimli_veri = {{16{!kayit_isaretsiz && kaydirilmis[15]}}, kaydirilmis[15:0]};
      default: bicimli_veri = kaydirilmis;
    endcase
  end

  // Transaction FSM with all bus and write-back outputs registered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum              <= BOSTA;
      bellek_istek_o     <= 1'b0;
      bellek_yaz_o       <= 1'b0;
      bellek_adres_o     <= '0;
      bellek_maske_o     <= '0;
      bellek_yaz_veri_o  <= '0;
      geri_yaz_gecerli_o <= 1'b0;
      geri_yaz_yazmac_o  <= '0;
      geri_yaz_veri_o    <= '0;
      hizasiz_hata_o     <= 1'b0;
      kayit_boyut        <= 2'b00;
      kayit_ofset        <= 2'b00;
      kayit_isaretsiz    <= 1'b0;
      kayit_hedef        <= '0;
    end else begin
      geri_yaz_gecerli_o <= 1'b0;
      hizasiz_hata_o     <= 1'b0;
      case (durum)
        BOSTA: begin
          if (istek_gecerli_i) begin
            if (hizasiz) begin
              hizasiz_hata_o <= 1'b1;
            end else begin
              bellek_istek_o    <= 1'b1;
              bellek_yaz_o      <= islem_i[3];
              bellek_adres_o    <= {adres_i[ADRES_W-1:2], 2'b00};
              bellek_maske_o    <= serit_maske;
              bellek_yaz_veri_o <= islem_i[3] ? serit_veri : VERI_W'(0);
              kayit_boyut       <= boyut;
              kayit_ofset       <= ofset;
              kayit_isaretsiz   <= islem_i[2];
              kayit_hedef       <= hedef_yazmac_i;
              durum             <= BEKLE;
            end
          end
        end
        BEKLE: begin
          if (bellek_hazir_i) begin
            bellek_istek_o <= 1'b0;
            durum          <= BOSTA;
            if (!bellek_yaz_o) begin
              geri_yaz_gecerli_o <= (kayit_hedef != YAZMAC_W'(0));
              geri_yaz_yazmac_o  <= kayit_hedef;
              geri_yaz_veri_o    <= bicimli_veri;
            end
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// Self-checking bench for bellek_erisim_birimi: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_bellek_erisim_birimi;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        istek_gecerli_i = 1'b0;
  logic [3:0]  islem_i = '0;
  logic [31:0] adres_i = '0;
  logic [31:0] yazilacak_veri_i = '0;
  logic [4:0]  hedef_yazmac_i = '0;
  logic        durdur_o;
  logic        bellek_istek_o;
  logic        bellek_yaz_o;
  logic [31:0] bellek_adres_o;
  logic [3:0]  bellek_maske_o;
  logic [31:0] bellek_yaz_veri_o;
  logic        bellek_hazir_i = 1'b0;
  logic [31:0] bellek_oku_veri_i = '0;
  logic        geri_yaz_gecerli_o;
  logic [4:0]  geri_yaz_yazmac_o;
  logic [31:0] geri_yaz_veri_o;
  logic        hizasiz_hata_o;

  int n_kars = 0;
  int n_hata = 0;

  bellek_erisim_birimi dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .istek_gecerli_i    (istek_gecerli_i),
    .islem_i            (islem_i),
    .adres_i            (adres_i),
    .yazilacak_veri_i   (yazilacak_veri_i),
    .hedef_yazmac_i     (hedef_yazmac_i),
    .durdur_o           (durdur_o),
    .bellek_istek_o     (bellek_istek_o),
    .bellek_yaz_o       (bellek_yaz_o),
    .bellek_adres_o     (bellek_adres_o),
    .bellek_maske_o     (bellek_maske_o),
    .bellek_yaz_veri_o  (bellek_yaz_veri_o),
    .bellek_hazir_i     (bellek_hazir_i),
    .bellek_oku_veri_i  (bellek_oku_veri_i),
    .geri_yaz_gecerli_o (geri_yaz_gecerli_o),
    .geri_yaz_yazmac_o  (geri_yaz_yazmac_o),
    .geri_yaz_veri_o    (geri_yaz_veri_o),
    .hizasiz_hata_o     (hizasiz_hata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_kars++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // Load result from plain arithmetic: shift down, truncate to the access size, sign-adjust
  function automatic logic [31:0] yukleme_sonucu(input logic [31:0] kelime, input int off,
                                                 input int boy, input bit isaretsiz);
    longint v;
    longint lim;
    v = longint'({32'h0, kelime}) >>> (8 * off);
    if (boy < 4) begin
      lim = 64'sd1 <<< (8 * boy);
      v = v % lim;
      if (!isaretsiz && v >= lim / 2) v = v - lim;
    end
    return v[31:0];
  endfunction

  // One operation from presentation to write-back; bekleme = memory wait cycles
  task automatic islem_yap(input logic [3:0] islem, input logic [31:0] adres, input logic [31:0] veri,
                           input logic [4:0] rd, input int bekleme, input logic [31:0] okunan);
    int          boy;
    int          off;
    bit          yaz;
    bit          mis;
    logic [31:0] e_adr;
    logic [3:0]  e_maske;
    logic [31:0] e_wdata;
    logic [31:0] e_sonuc;
    bit          e_gy;

    yaz     = islem[3];
    boy     = (islem[1:0] == 2'd0) ? 1 : (islem[1:0] == 2'd1) ? 2 : 4;
    off     = int'(adres % 4);
    mis     = (int'(adres % 32'(boy)) != 0);
    e_adr   = adres - 32'(off);
    e_maske = 4'(((1 << boy) - 1) << off);
    if (!yaz)          e_wdata = 32'h0;
    else if (boy == 1) e_wdata = 32'(veri[7:0]) * 32'h0101_0101;
    else if (boy == 2) e_wdata = 32'(veri[15:0]) * 32'h0001_0001;
    else               e_wdata = veri;
    e_sonuc = yukleme_sonucu(okunan, off, boy, islem[2]);
    e_gy    = !yaz && (rd != 5'd0);

    @(posedge clk_i); #1;
    istek_gecerli_i  = 1'b1;
    islem_i          = islem;
    adres_i          = adres;
    yazilacak_veri_i = veri;
    hedef_yazmac_i   = rd;
    bellek_hazir_i   = 1'($urandom);
    bellek_oku_veri_i = $urandom;
    @(negedge clk_i);
    kontrol("durdur_kabul", 32'(durdur_o), 32'(!mis));
    kontrol("istek_bosta", 32'(bellek_istek_o), 32'h0);
    kontrol("gy_bosta", 32'(geri_yaz_gecerli_o), 32'h0);
    kontrol("hata_bosta", 32'(hizasiz_hata_o), 32'h0);

    if (mis) begin
      @(posedge clk_i); #1;
      istek_gecerli_i = 1'b0;
      bellek_hazir_i  = 1'b0;
      @(negedge clk_i);
      kontrol("hata_darbe", 32'(hizasiz_hata_o), 32'h1);
      kontrol("hata_istek_yok", 32'(bellek_istek_o), 32'h0);
      kontrol("hata_gy_yok", 32'(geri_yaz_gecerli_o), 32'h0);
      return;
    end

    @(posedge clk_i); #1;
    for (int k = 0; k <= bekleme; k++) begin
      bellek_hazir_i    = (k == bekleme);
      bellek_oku_veri_i = (k == bekleme) ? okunan : $urandom;
      @(negedge clk_i);
      kontrol("bus_istek", 32'(bellek_istek_o), 32'h1);
      kontrol("bus_yaz", 32'(bellek_yaz_o), 32'(yaz));
      kontrol("bus_adres", bellek_adres_o, e_adr);
      kontrol("bus_maske", 32'(bellek_maske_o), 32'(e_maske));
      kontrol("bus_veri", bellek_yaz_veri_o, e_wdata);
      kontrol("durdur_bekle", 32'(durdur_o), 32'(k != bekleme));
      kontrol("gy_bekle", 32'(geri_yaz_gecerli_o), 32'h0);
      @(posedge clk_i); #1;
    end
    istek_gecerli_i = 1'b0;
    bellek_hazir_i  = 1'b0;
    @(negedge clk_i);
    kontrol("istek_dustu", 32'(bellek_istek_o), 32'h0);
    kontrol("gy_gecerli", 32'(geri_yaz_gecerli_o), 32'(e_gy));
    if (e_gy) begin
      kontrol("gy_veri", geri_yaz_veri_o, e_sonuc);
      kontrol("gy_yazmac", 32'(geri_yaz_yazmac_o), 32'(rd));
    end
  endtask

  initial begin
    #1;
    kontrol("rst_istek", 32'(bellek_istek_o), 32'h0);
    kontrol("rst_yaz", 32'(bellek_yaz_o), 32'h0);
    kontrol("rst_adres", bellek_adres_o, 32'h0);
    kontrol("rst_maske", 32'(bellek_maske_o), 32'h0);
    kontrol("rst_veri", bellek_yaz_veri_o, 32'h0);
    kontrol("rst_gy", 32'(geri_yaz_gecerli_o), 32'h0);
    kontrol("rst_gy_yazmac", 32'(geri_yaz_yazmac_o), 32'h0);
    kontrol("rst_gy_veri", geri_yaz_veri_o, 32'h0);
    kontrol("rst_hata", 32'(hizasiz_hata_o), 32'h0);
    kontrol("rst_durdur", 32'(durdur_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Directed cases
    islem_yap(4'b0010, 32'h100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);   // LW
    islem_yap(4'b0000, 32'h103, 32'h0, 5'd6, 0, 32'h80FF_FF7F);   // LB
    islem_yap(4'b0100, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_FF7F);   // LBU
    islem_yap(4'b0101, 32'h102, 32'h0, 5'd8, 0, 32'h80FF_FF7F);   // LHU
    islem_yap(4'b0001, 32'h102, 32'h0, 5'd9, 2, 32'h80FF_FF7F);   // LH
    islem_yap(4'b1000, 32'h201, 32'h1234_5678, 5'd3, 0, 32'h0);   // SB
    islem_yap(4'b1001, 32'h202, 32'h1234_5678, 5'd3, 3, 32'h0);   // SH, 3 waits
    islem_yap(4'b0010, 32'h102, 32'h0, 5'd4, 0, 32'h0);           // LW misaligned
    islem_yap(4'b0001, 32'h101, 32'h0, 5'd4, 0, 32'h0);           // LH misaligned
    islem_yap(4'b0011, 32'h300, 32'h0, 5'd0, 0, 32'h1111_2222);   // load to x0

    // Reset while a load is outstanding
    @(posedge clk_i); #1;
    istek_gecerli_i = 1'b1;
    islem_i         = 4'b0010;
    adres_i         = 32'h400;
    hedef_yazmac_i  = 5'd10;
    bellek_hazir_i  = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    kontrol("rst_oncesi_istek", 32'(bellek_istek_o), 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    istek_gecerli_i = 1'b0;
    #1;
    kontrol("rst_ani_istek", 32'(bellek_istek_o), 32'h0);
    @(posedge clk_i); #1;
    bellek_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      kontrol("rst_sonra_gy", 32'(geri_yaz_gecerli_o), 32'h0);
      kontrol("rst_sonra_istek", 32'(bellek_istek_o), 32'h0);
    end
    bellek_hazir_i = 1'b0;
    islem_yap(4'b0010, 32'h400, 32'h0, 5'd10, 0, 32'hCAFE_F00D);

    // Random operations
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  r_islem;
      logic [31:0] r_adres;
      logic [4:0]  r_rd;
      r_islem = 4'($urandom);
      r_adres = $urandom;
      if ($urandom_range(0, 1) == 0) r_adres[1:0] = 2'b00;
      r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      islem_yap(r_islem, r_adres, $urandom, r_rd, $urandom_range(0, 3), $urandom);
    end

    @(posedge clk_i); #1;
    @(negedge clk_i);
    kontrol("son_gy", 32'(geri_yaz_gecerli_o), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_kars, n_hata);
    $finish;
  end

endmodule

// File: doc/bellek_erisim_birimi.md
# bellek_erisim_birimi

Load/store unit of the memory stage, directly downstream of the execute-stage ALU. It takes the ALU sum as the effective address and runs one word-wide transaction on the data-memory port with a valid/ready handshake. It generates byte-lane masks and aligned store data, and formats returned load data with sign or zero extension. It stalls the upstream stage while a transaction is outstanding and produces a single-cycle write-back pulse for loads.

## Interface
Parameters: none. Fixed widths: 32-bit address and data, 5-bit register index.

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- istek_gecerli_i  in  1  execute stage presents a memory operation
- islem_i  in  4  [3] 1=store / 0=load; [2] unsigned load (LBU/LHU), ignored for stores; [1:0] size 00=byte, 01=half, 10=word, 11=reserved (treated as word)
- adres_i  in  32  effective address (ALU addition result)
- yazilacak_veri_i  in  32  store data (rs2)
- hedef_yazmac_i  in  5  load destination register
- durdur_o  out  1  combinational stall to upstream; upstream holds all inputs while 1
- bellek_istek_o  out  1  bus request valid (registered)
- bellek_yaz_o  out  1  1=write, 0=read (registered)
- bellek_adres_o  out  32  {adres_i[31:2],2'b00} (registered)
- bellek_maske_o  out  4  byte-lane enables (registered)
- bellek_yaz_veri_o  out  32  lane-replicated store data (registered)
- bellek_hazir_i  in  1  memory accepts/completes the request in this cycle
- bellek_oku_veri_i  in  32  read word, valid when bellek_hazir_i=1 on a read
- geri_yaz_gecerli_o  out  1  one-cycle write-back pulse
- geri_yaz_yazmac_o  out  5  write-back register index
- geri_yaz_veri_o  out  32  formatted load result
- hizasiz_hata_o  out  1  one-cycle misaligned-access pulse

## Operation
- States: BOSTA (idle), BEKLE (request outstanding).
- Misaligned access: half with adres_i[0]=1, or word with adres_i[1:0]≠0. Byte accesses are never misaligned.
- BOSTA with istek_gecerli_i=1 and aligned access:
  - Capture address, lanes, data, type and destination into the bus registers.
  - Assert bellek_istek_o next cycle; go to BEKLE.
  - durdur_o=1.
- BOSTA with istek_gecerli_i=1 and misaligned access:
  - No bus request is issued.
  - hizasiz_hata_o=1 next cycle.
  - durdur_o=0, so the operation is consumed.
- BEKLE:
  - Bus outputs stay stable until a cycle with bellek_hazir_i=1.
  - durdur_o=!bellek_hazir_i.
  - In the hazir cycle: go to BOSTA and clear bellek_istek_o. For a load, register the formatted data and pulse geri_yaz_gecerli_o next cycle.
- Operation consumed: any cycle with istek_gecerli_i=1 and durdur_o=0.
- Store lanes, with off=adres_i[1:0]:
  - byte: mask 4'b0001<<off, data {4{rs2[7:0]}}
  - half: mask 4'b0011<<off, data {2{rs2[15:0]}}
  - word: mask 4'b1111, data rs2
- Loads: bellek_maske_o as for stores, bellek_yaz_veri_o=0. Result = bellek_oku_veri_i>>(8*off), then:
  - byte: sign- or zero-extend bits [7:0] per islem_i[2]
  - half: sign- or zero-extend bits [15:0] per islem_i[2]
  - word: unchanged
- Loads to x0 still run the bus transaction; geri_yaz_gecerli_o is suppressed.
- Stores never assert geri_yaz_gecerli_o.

## Timing
- Reset: asynchronous. State=BOSTA; every registered output is 0 (bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_maske_o, bellek_yaz_veri_o, geri_yaz_*, hizasiz_hata_o).
- Reset mid-transaction abandons the request: bellek_istek_o falls immediately, and no write-back or error follows.
- Minimum latency with the operation accepted at cycle T:
  - bellek_istek_o high at T+1
  - bellek_hazir_i sampled high at T+1
  - geri_yaz_gecerli_o high at T+2
  - durdur_o high at T only (stall of 1 cycle); each wait cycle from memory adds one stall cycle.
- Back-to-back: the next operation is presented in the cycle after the hazir cycle and is accepted in BOSTA there. The bus is therefore idle for at least one cycle between requests.
- bellek_hazir_i is ignored in BOSTA.
- Write-back and error pulses last exactly one cycle.
- durdur_o depends only on the current state, istek_gecerli_i, the misalignment check and bellek_hazir_i. It has no dependency on registered outputs of the same cycle.

## Test plan
- LW at 0x100, memory ready immediately, read 0xDEADBEEF:
  - bellek_istek_o at T+1 with addr 0x100, mask 1111, yaz=0
  - geri_yaz_gecerli_o at T+2 with 0xDEADBEEF
  - durdur_o high 1 cycle
- LB at 0x103, read 0x80FF_FF7F: result 0xFFFFFF80. LBU at 0x103: 0x00000080. LHU at 0x102: 0x000080FF.
- SB at 0x201 with rs2=0x12345678:
  - addr 0x200, mask 0010, data 0x78787878, yaz=1
  - no write-back
- SH at 0x202 with 3 wait cycles (hazir at T+4): outputs stable from T+1 to T+4, durdur_o high T..T+3, mask 1100.
- LW at 0x102: hizasiz_hata_o pulse at T+1, no bellek_istek_o, durdur_o=0 at T.
- rst_i asserted at T+2 while waiting on a load: bellek_istek_o=0 immediately, no geri_yaz_gecerli_o. The next LW after reset completes normally.
